sa_cache_4way: RTL and testbench

- 4-way set-associative, write-back, write-allocate data cache between a 32-bit core port and a word-serial memory port.
- Address is pre-split into an 18-bit tag, an 8-bit index and a 6-bit byte offset: 256 sets, 64-byte lines of 16 words.
- Hits complete combinationally. Misses run an evict/refill sequence against memory while the requester holds the request stable.

---
 rtl/sa_cache_4way.sv | 220 ++++++++++++++++++++++
 tb/tb_sa_cache_4way.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_4way.sv
// sa_cache_4way: 4-way set-associative cache, tree pseudo-LRU, combinational hits, word-serial evict/refill.
// Define SA_CACHE_WRITE_THROUGH_EN for write-through operation (no dirty lines, one o_evict beat per write hit).
module sa_cache_4way #(
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 6,
  parameter int DATA_W   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TAG_W-1:0]                  i_tag,
  input  logic [INDEX_W-1:0]                i_index,
  input  logic [OFFSET_W-1:0]               i_offset,
  input  logic [DATA_W-1:0]                 dataW,
  input  logic                              memRW,
  input  logic [DATA_W-1:0]                 i_memory_line,
  input  logic                              i_memory_response,
  output logic [DATA_W-1:0]                 o_data,
  output logic [DATA_W-1:0]                 line_data,
  output logic                              cache_miss,
  output logic [DATA_W-1:0]                 o_evict_data,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] o_evict_addr,
  output logic                              o_evict
);
  localparam int WAYS   = 4;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int WORDS  = 1 << WORD_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_REFILL} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WORD_W-1:0]    r_beat;
  logic [1:0]           r_victim;
  logic [TAG_W-1:0]     r_req_tag;
  logic [INDEX_W-1:0]   r_req_index;
  logic [SETS-1:0]      r_valid [WAYS];
  logic [SETS-1:0]      r_dirty [WAYS];
  logic [2:0]           r_plru  [SETS];

  logic [WORD_W-1:0]         w_word;
  logic [INDEX_W+WORD_W-1:0] w_rd_addr;
  logic [INDEX_W+WORD_W-1:0] w_fill_addr;
  logic [WAYS-1:0]           w_way_hit;
  logic                      w_hit;
  logic [1:0]                w_hit_way;
  logic [DATA_W-1:0]         w_way_word  [WAYS];
  logic [DATA_W-1:0]         w_way_evict [WAYS];
  logic [TAG_W-1:0]          w_way_tag   [WAYS];
  logic [2:0]                w_plru_cur;
  logic [2:0]                w_plru_upd;
  logic [1:0]                w_plru_way;
  logic [1:0]                w_victim;
  logic                      w_victim_dirty;
  logic                      w_hit_we;
  logic                      w_fill_we;
  logic                      w_plru_we;
  logic [1:0]                w_unused_byte_sel;

  assign w_word            = i_offset[OFFSET_W-1:2];
  assign w_rd_addr         = {i_index, w_word};
  assign w_fill_addr       = {r_req_index, r_beat};
  assign w_unused_byte_sel = i_offset[1:0];

  // One tag array and one data array per way; each is written by at most one source per cycle.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  r_tag_mem [SETS];
      logic [DATA_W-1:0] r_mem     [SETS*WORDS];

      always_ff @(posedge clk) begin
        if (w_hit_we && (w_hit_way == 2'(gi))) begin
          r_mem[w_rd_addr] <= dataW;
        end else if (w_fill_we && (r_victim == 2'(gi))) begin
          r_mem[w_fill_addr] <= i_memory_line;
          if (r_beat == LAST_BEAT) begin
            r_tag_mem[r_req_index] <= r_req_tag;
          end
        end
      end

      assign w_way_tag[gi]   = r_tag_mem[i_index];
      assign w_way_hit[gi]   = r_valid[gi][i_index] && (w_way_tag[gi] == i_tag);
      assign w_way_word[gi]  = r_mem[w_rd_addr];
      assign w_way_evict[gi] = r_mem[w_fill_addr];
    end
  endgenerate

  assign w_hit = |w_way_hit;

  always_comb begin
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_way_hit[i]) w_hit_way = 2'(i);
    end
  end

  // Tree bits: [0] = older half (1 -> ways 2/3), [1] = older of ways 0/1, [2] = older of ways 2/3.
  assign w_plru_cur = r_plru[i_index];
  assign w_plru_way = w_plru_cur[0] ? {1'b1, w_plru_cur[2]} : {1'b0, w_plru_cur[1]};

  always_comb begin
    w_plru_upd    = w_plru_cur;
    w_plru_upd[0] = ~w_hit_way[1];
    if (w_hit_way[1]) w_plru_upd[2] = ~w_hit_way[0];
    else              w_plru_upd[1] = ~w_hit_way[0];
  end

  always_comb begin
    w_victim = w_plru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[i][i_index]) w_victim = 2'(i);
    end
  end

  assign w_victim_dirty = r_valid[w_victim][i_index] && r_dirty[w_victim][i_index];

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    o_data       = '0;
    line_data    = '0;
    cache_miss   = 1'b0;
    o_evict      = 1'b0;
    o_evict_data = '0;
    o_evict_addr = '0;
    w_hit_we     = 1'b0;
    w_fill_we    = 1'b0;
    w_plru_we    = 1'b0;
    if (rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            o_data    = w_way_word[w_hit_way];
            w_plru_we = 1'b1;
            if (memRW) begin
              w_hit_we = 1'b1;
`ifdef SA_CACHE_WRITE_THROUGH_EN
              o_evict      = 1'b1;
              o_evict_data = dataW;
              o_evict_addr = {i_tag, i_index, w_word, 2'b00};
`endif
            end
          end else begin
            cache_miss   = 1'b1;
            w_state_next = w_victim_dirty ? S_EVICT : S_REFILL;
          end
        end
        S_EVICT: begin
          cache_miss   = 1'b1;
          o_evict      = 1'b1;
          o_evict_data = w_way_evict[r_victim];
          o_evict_addr = {w_way_tag[r_victim], r_req_index, r_beat, 2'b00};
          if (r_beat == LAST_BEAT) w_state_next = S_REFILL;
        end
        S_REFILL: begin
          cache_miss = 1'b1;
          if (i_memory_response) begin
            line_data = i_memory_line;
            w_fill_we = 1'b1;
            if (r_beat == LAST_BEAT) w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_victim    <= '0;
      r_req_tag   <= '0;
      r_req_index <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (!w_hit) begin
            // Victim is invalidated now so an aborted refill can never leave a half-filled valid line.
            r_victim                  <= w_victim;
            r_req_tag                 <= i_tag;
            r_req_index               <= i_index;
            r_valid[w_victim][i_index] <= 1'b0;
          end
        end
        S_EVICT: begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) r_dirty[r_victim][r_req_index] <= 1'b0;
        end
        S_REFILL: begin
          if (w_fill_we) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              r_valid[r_victim][r_req_index] <= 1'b1;
              r_dirty[r_victim][r_req_index] <= 1'b0;
            end
          end
        end
        default: r_beat <= '0;
      endcase
      if (w_plru_we) r_plru[i_index] <= w_plru_upd;
`ifndef SA_CACHE_WRITE_THROUGH_EN
      if (w_hit_we) r_dirty[w_hit_way][i_index] <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_sa_cache_4way.sv
// Randomised self-checking bench for sa_cache_4way against a line-level cache model (default write-back build).
module tb_sa_cache_4way;
  logic        clk;
  logic        rst;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic [5:0]  i_offset;
  logic [31:0] dataW;
  logic        memRW;
  logic [31:0] i_memory_line;
  logic        i_memory_response;
  logic [31:0] o_data;
  logic [31:0] line_data;
  logic        cache_miss;
  logic [31:0] o_evict_data;
  logic [31:0] o_evict_addr;
  logic        o_evict;

  int vectors;
  int miscompares;

  // Reference model: contents of every line plus, per set, which half and which way of each pair is older.
  bit          m_valid [4][256];
  bit          m_dirty [4][256];
  logic [17:0] m_tag   [4][256];
  logic [31:0] m_data  [4][256][16];
  bit          m_old_half    [256];
  bit          m_old_in_pair [256][2];

  bit          use_seq;
  logic [31:0] seq_base;
  logic [31:0] obs_evict_data [16];
  logic [31:0] obs_evict_addr [16];

  sa_cache_4way dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line),
    .i_memory_response(i_memory_response), .o_data(o_data), .line_data(line_data),
    .cache_miss(cache_miss), .o_evict_data(o_evict_data), .o_evict_addr(o_evict_addr),
    .o_evict(o_evict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 256; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    for (int s = 0; s < 256; s++) begin
      m_old_half[s]       = 0;
      m_old_in_pair[s][0] = 0;
      m_old_in_pair[s][1] = 0;
    end
  endfunction

  function automatic int m_find(input logic [17:0] t, input logic [7:0] ix);
    for (int w = 0; w < 4; w++)
      if (m_valid[w][ix] && m_tag[w][ix] == t) return w;
    return -1;
  endfunction

  function automatic int m_pick_victim(input logic [7:0] ix);
    int half;
    for (int w = 0; w < 4; w++)
      if (!m_valid[w][ix]) return w;
    half = int'(m_old_half[ix]);
    return half * 2 + int'(m_old_in_pair[ix][half]);
  endfunction

  function automatic void m_touch(input logic [7:0] ix, input int w);
    m_old_half[ix] = (w < 2);
    m_old_in_pair[ix][w / 2] = (w % 2 == 0);
  endfunction

  task automatic access(input logic [17:0] t, input logic [7:0] ix, input logic [5:0] off,
                        input logic rw, input logic [31:0] wd, input int stall_beat);
    int w, v, word;
    bit ev;
    logic [31:0] fill, exp_addr;
    logic [3:0] kk;
    word = int'(off[5:2]);
    i_tag = t; i_index = ix; i_offset = off; memRW = rw; dataW = wd; i_memory_response = 1'b0;
    @(negedge clk);
    w = m_find(t, ix);
    $display("txn tag=%05h idx=%02h off=%02h %s data=%08h %s", t, ix, off, rw ? "WR" : "RD", wd,
             (w < 0) ? "miss" : "hit");
    if (w < 0) begin
      vectors++;
      if (cache_miss !== 1'b1 || o_data !== 32'h0) begin
        miscompares++;
        $display("FAIL miss_detect: cache_miss=%b o_data=%08h, required 1 / 00000000", cache_miss, o_data);
      end
      v  = m_pick_victim(ix);
      ev = m_valid[v][ix] && m_dirty[v][ix];
      @(posedge clk); #1;
      if (ev) begin
        for (int k = 0; k < 16; k++) begin
          kk = 4'(k);
          exp_addr = {m_tag[v][ix], ix, kk, 2'b00};
          @(negedge clk);
          obs_evict_data[k] = o_evict_data;
          obs_evict_addr[k] = o_evict_addr;
          vectors++;
          if (o_evict !== 1'b1 || cache_miss !== 1'b1 || o_evict_addr !== exp_addr || o_evict_data !== m_data[v][ix][k]) begin
            miscompares++;
            $display("FAIL evict_beat%0d: evict=%b miss=%b addr=%08h data=%08h, required 1 1 %08h %08h",
                     k, o_evict, cache_miss, o_evict_addr, o_evict_data, exp_addr, m_data[v][ix][k]);
          end
          @(posedge clk); #1;
        end
      end
      m_valid[v][ix] = 0;
      for (int k = 0; k < 16; k++) begin
        if (k == stall_beat) begin
          repeat (3) begin
            i_memory_response = 1'b0;
            i_memory_line = $urandom;
            @(negedge clk);
            vectors++;
            if (cache_miss !== 1'b1 || line_data !== 32'h0 || o_evict !== 1'b0) begin
              miscompares++;
              $display("FAIL refill_stall: miss=%b line_data=%08h evict=%b, required 1 00000000 0",
                       cache_miss, line_data, o_evict);
            end
            @(posedge clk); #1;
          end
        end
        fill = use_seq ? seq_base + 32'(k) : $urandom;
        i_memory_line = fill;
        i_memory_response = 1'b1;
        @(negedge clk);
        vectors++;
        if (line_data !== fill || cache_miss !== 1'b1 || o_evict !== 1'b0) begin
          miscompares++;
          $display("FAIL refill_beat%0d: line_data=%08h miss=%b evict=%b, required %08h 1 0",
                   k, line_data, cache_miss, o_evict, fill);
        end
        m_data[v][ix][k] = fill;
        @(posedge clk); #1;
      end
      i_memory_response = 1'b0;
      m_valid[v][ix] = 1;
      m_dirty[v][ix] = 0;
      m_tag[v][ix]   = t;
      w = v;
      @(negedge clk);
    end
    vectors++;
    if (cache_miss !== 1'b0 || o_data !== m_data[w][ix][word] || o_evict !== 1'b0) begin
      miscompares++;
      $display("FAIL hit: miss=%b o_data=%08h evict=%b, required 0 %08h 0",
               cache_miss, o_data, o_evict, m_data[w][ix][word]);
    end
    if (rw) begin
      m_data[w][ix][word] = wd;
      m_dirty[w][ix] = 1;
    end
    m_touch(ix, w);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_tag = '0; i_index = '0; i_offset = '0; dataW = '0; memRW = 1'b0;
    i_memory_line = '0; i_memory_response = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cache_miss !== 1'b0 || o_data !== 32'h0 || line_data !== 32'h0 || o_evict !== 1'b0 ||
        o_evict_data !== 32'h0 || o_evict_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: miss=%b data=%08h line=%08h evict=%b edata=%08h eaddr=%08h, required all zero",
               cache_miss, o_data, line_data, o_evict, o_evict_data, o_evict_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_first_fill();
    use_seq = 1; seq_base = 32'h1000;
    access(18'h0, 8'h0, 6'h00, 1'b0, 32'h0, -1);
    vectors++;
    if (o_data !== 32'h1000) begin
      miscompares++;
      $display("FAIL first_fill: o_data=%08h, required 00001000", o_data);
    end
  endtask

  task automatic test_read_hits();
    logic [5:0] offs [4];
    offs = '{6'h04, 6'h08, 6'h0C, 6'h10};
    for (int i = 0; i < 4; i++) begin
      access(18'h0, 8'h0, offs[i], 1'b0, 32'h0, -1);
      vectors++;
      if (o_data !== 32'h1001 + 32'(i) || cache_miss !== 1'b0) begin
        miscompares++;
        $display("FAIL read_hit_%0d: o_data=%08h miss=%b, required %08h 0", i, o_data, cache_miss, 32'h1001 + 32'(i));
      end
    end
  endtask

  task automatic test_write_hit();
    access(18'h0, 8'h0, 6'h08, 1'b1, 32'hDEADBEEF, -1);
    access(18'h0, 8'h0, 6'h08, 1'b0, 32'h0, -1);
    vectors++;
    if (o_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_readback: o_data=%08h, required deadbeef", o_data);
    end
  endtask

  task automatic test_evict();
    for (int t = 1; t <= 4; t++) begin
      seq_base = 32'h1000 * 32'(t + 1);
      access(18'(t), 8'h0, 6'h00, 1'b0, 32'h0, -1);
    end
    vectors++;
    if (obs_evict_data[2] !== 32'hDEADBEEF || obs_evict_addr[0] !== 32'h0 || obs_evict_addr[15] !== 32'h3C) begin
      miscompares++;
      $display("FAIL evict_line: beat2=%08h addr0=%08h addr15=%08h, required deadbeef 00000000 0000003c",
               obs_evict_data[2], obs_evict_addr[0], obs_evict_addr[15]);
    end
  endtask

  task automatic test_stall();
    seq_base = 32'h5000;
    access(18'h5, 8'h1, 6'h00, 1'b0, 32'h0, 7);
    for (int k = 6; k <= 8; k++) begin
      access(18'h5, 8'h1, 6'(k * 4), 1'b0, 32'h0, -1);
      vectors++;
      if (o_data !== 32'h5000 + 32'(k)) begin
        miscompares++;
        $display("FAIL stall_word%0d: o_data=%08h, required %08h", k, o_data, 32'h5000 + 32'(k));
      end
    end
  endtask

  task automatic test_random();
    use_seq = 0;
    for (int n = 0; n < 60; n++) begin
      access(18'($urandom_range(0, 5)), 8'($urandom_range(2, 3)), 6'($urandom_range(0, 63)),
             1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
    end
  endtask

  task automatic test_reset_refill();
    i_tag = 18'h9; i_index = 8'h4; i_offset = 6'h0; memRW = 1'b0; i_memory_response = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      i_memory_line = $urandom;
      i_memory_response = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (cache_miss !== 1'b0 || line_data !== 32'h0 || o_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_refill: miss=%b line=%08h data=%08h, required 0 00000000 00000000",
               cache_miss, line_data, o_data);
    end
    i_memory_response = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_clear();
    access(18'h9, 8'h4, 6'h00, 1'b0, 32'h0, -1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    use_seq = 0;
    seq_base = '0;
    test_reset();
    test_first_fill();
    test_read_hits();
    test_write_hit();
    test_evict();
    test_stall();
    test_random();
    test_reset_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
